pcie_us_rq_tag_pool: RTL and testbench

//  Requester tag allocator for the UltraScale/UltraScale+ PCIe RQ interface. Hands out free
//  non-posted request tags over a ready/valid handshake and reclaims them on RC completion.

---
 rtl/pcie_us_rq_tag_pool.sv | 114 +++++++++++
 tb/tb_pcie_us_rq_tag_pool.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pcie_us_rq_tag_pool.sv
// Requester tag allocator for the UltraScale PCIe RQ interface: offers free non-posted
// tags over ready/valid, reclaims them on final completion, and tracks outstanding tags.
module pcie_us_rq_tag_pool #(
    parameter int TAG_WIDTH = 8,
    parameter int TAG_COUNT = 256,
    parameter int CNT_WIDTH = $clog2(TAG_COUNT + 1)
) (
    input  logic                 user_clk,
    input  logic                 user_reset,
    input  logic                 ext_tag_enable,
    input  logic                 flush,
    output logic [TAG_WIDTH-1:0] m_axis_tag,
    output logic                 m_axis_tag_valid,
    input  logic                 m_axis_tag_ready,
    input  logic [TAG_WIDTH-1:0] s_release_tag,
    input  logic                 s_release_valid,
    output logic [CNT_WIDTH-1:0] tag_count,
    output logic                 err_release
);

    localparam int NARROW_LIMIT = (TAG_COUNT < 32) ? TAG_COUNT : 32;

    logic [TAG_COUNT-1:0] in_use_q, in_use_d;
    logic [TAG_COUNT-1:0] alloc_hit, rel_hit;
    logic [CNT_WIDTH-1:0] tag_count_q, tag_count_d;
    logic [TAG_WIDTH-1:0] offer_tag_q, offer_tag_d;
    logic                 offer_valid_q, offer_valid_d;
    logic                 err_q, err_d;
    logic                 handshake;
    logic                 rel_ok;
    logic                 free_found;
    logic [TAG_WIDTH-1:0] free_tag;
    int                   limit;

    assign handshake = offer_valid_q & m_axis_tag_ready;

    // Per-tag decode avoids indexing the bitmap with out-of-range tag values.
    genvar gi;
    generate
        for (gi = 0; gi < TAG_COUNT; gi++) begin : g_tag
            assign alloc_hit[gi] = handshake && (offer_tag_q == TAG_WIDTH'(gi));
            assign rel_hit[gi]   = s_release_valid && (s_release_tag == TAG_WIDTH'(gi));
        end
    endgenerate

    // A release of the tag allocated this same cycle sees it still free and is an error.
    assign rel_ok = |(rel_hit & in_use_q);

    always_comb begin
        in_use_d    = in_use_q;
        tag_count_d = tag_count_q;
        err_d       = 1'b0;
        if (flush) begin
            in_use_d    = '0;
            tag_count_d = '0;
        end else begin
            in_use_d    = (in_use_q | alloc_hit) & ~(rel_hit & in_use_q);
            tag_count_d = tag_count_q + CNT_WIDTH'(handshake) - CNT_WIDTH'(rel_ok);
            err_d       = s_release_valid & ~rel_ok;
        end
    end

    // Lowest free tag below the active limit, taken from the post-edge bitmap.
    always_comb begin
        limit      = ext_tag_enable ? TAG_COUNT : NARROW_LIMIT;
        free_found = 1'b0;
        free_tag   = '0;
        for (int i = TAG_COUNT - 1; i >= 0; i--) begin
            if (!in_use_d[i] && (i < limit)) begin
                free_found = 1'b1;
                free_tag   = TAG_WIDTH'(i);
            end
        end
    end

    always_comb begin
        offer_tag_d   = offer_tag_q;
        offer_valid_d = offer_valid_q;
        if (!offer_valid_q || handshake || flush) begin
            offer_valid_d = free_found;
            if (free_found) begin
                offer_tag_d = free_tag;
            end
        end
    end

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            in_use_q      <= '0;
            tag_count_q   <= '0;
            offer_tag_q   <= '0;
            offer_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            in_use_q      <= in_use_d;
            tag_count_q   <= tag_count_d;
            offer_tag_q   <= offer_tag_d;
            offer_valid_q <= offer_valid_d;
            err_q         <= err_d;
        end
    end

    always @(posedge user_clk) begin
        if (!user_reset) begin
            assert ($countones(in_use_q) == int'(tag_count_q));
        end
    end

    assign m_axis_tag       = offer_tag_q;
    assign m_axis_tag_valid = offer_valid_q;
    assign tag_count        = tag_count_q;
    assign err_release      = err_q;

endmodule

// File: tb/tb_pcie_us_rq_tag_pool.sv
// Scoreboard bench for pcie_us_rq_tag_pool: stimulus queues expected tags and error
// pulses, a negedge monitor checks every handshake and every err_release pulse.
module tb_pcie_us_rq_tag_pool;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ext = 1'b1;
    logic       flush = 1'b0;
    logic [7:0] tag;
    logic       tag_valid;
    logic       tag_ready = 1'b0;
    logic [7:0] rel_tag = '0;
    logic       rel_valid = 1'b0;
    logic [8:0] count;
    logic       err;

    logic [7:0] tag2;
    logic       tag2_valid;
    logic [7:0] rel2_tag = '0;
    logic       rel2_valid = 1'b0;
    logic [7:0] count2;
    logic       err2;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_tag_q[$];
    int exp_err_q[$];

    always #5 clk = ~clk;

    pcie_us_rq_tag_pool #(.TAG_WIDTH(8), .TAG_COUNT(256)) dut (
        .user_clk(clk), .user_reset(rst), .ext_tag_enable(ext), .flush(flush),
        .m_axis_tag(tag), .m_axis_tag_valid(tag_valid), .m_axis_tag_ready(tag_ready),
        .s_release_tag(rel_tag), .s_release_valid(rel_valid),
        .tag_count(count), .err_release(err)
    );

    pcie_us_rq_tag_pool #(.TAG_WIDTH(8), .TAG_COUNT(200)) dut2 (
        .user_clk(clk), .user_reset(rst), .ext_tag_enable(1'b1), .flush(1'b0),
        .m_axis_tag(tag2), .m_axis_tag_valid(tag2_valid), .m_axis_tag_ready(1'b0),
        .s_release_tag(rel2_tag), .s_release_valid(rel2_valid),
        .tag_count(count2), .err_release(err2)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0d", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input int first, input int n);
        for (int k = 0; k < n; k++) exp_tag_q.push_back(first + k);
        tag_ready = 1'b1;
        repeat (n) tick();
        tag_ready = 1'b0;
    endtask

    task automatic release_tag(input int t, input int bad);
        if (bad != 0) exp_err_q.push_back(t);
        rel_tag   = 8'(t);
        rel_valid = 1'b1;
        tick();
        rel_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // Monitor: every presented handshake and every error pulse must be expected.
    always @(negedge clk) begin
        if (!rst) begin
            if (tag_valid && tag_ready) begin
                if (exp_tag_q.size() == 0) chk("unexpected_handshake_tag", int'(tag), -1);
                else chk("alloc_tag", int'(tag), exp_tag_q.pop_front());
            end
            if (err) begin
                if (exp_err_q.size() == 0) chk("unexpected_err_release", 1, 0);
                else chk("err_release_for_tag", int'(rel_tag), exp_err_q.pop_front());
            end
        end
    end

    initial begin
        #22;
        chk("reset_valid", int'(tag_valid), 0);
        chk("reset_tag", int'(tag), 0);
        chk("reset_count", int'(count), 0);
        chk("reset_err", int'(err), 0);
        #1 rst = 1'b0;
        tick();
        chk("first_offer_valid", int'(tag_valid), 1);
        chk("first_offer_tag", int'(tag), 0);

        // 1: three back-to-back accepts
        accept(0, 3);
        chk("t1_count", int'(count), 3);
        do_flush();

        // 2: 5-bit mode fills at 32, released tag re-offered next cycle
        ext = 1'b0;
        accept(0, 32);
        chk("t2_full_valid", int'(tag_valid), 0);
        chk("t2_full_count", int'(count), 32);
        release_tag(5, 0);
        chk("t2_reoffer_valid", int'(tag_valid), 1);
        chk("t2_reoffer_tag", int'(tag), 5);
        chk("t2_count", int'(count), 31);
        accept(5, 1);
        ext = 1'b1;
        do_flush();

        // 3: double release -> single error pulse, held offer unchanged
        accept(0, 10);
        release_tag(7, 0);
        chk("t3_count_after_rel", int'(count), 9);
        release_tag(7, 1);
        chk("t3_err_pulse", int'(err), 1);
        tick();
        chk("t3_err_cleared", int'(err), 0);
        chk("t3_count", int'(count), 9);
        chk("t3_offer_held", int'(tag), 10);
        do_flush();

        // 4: simultaneous accept and release
        accept(0, 4);
        chk("t4_offer", int'(tag), 4);
        exp_tag_q.push_back(4);
        tag_ready = 1'b1;
        release_tag(1, 0);
        tag_ready = 1'b0;
        chk("t4_count", int'(count), 4);
        chk("t4_next_offer", int'(tag), 1);
        chk("t4_next_valid", int'(tag_valid), 1);
        do_flush();

        // 5: flush beats same-cycle handshake and release
        accept(0, 10);
        exp_tag_q.push_back(10);
        tag_ready = 1'b1;
        flush = 1'b1;
        release_tag(3, 0);
        tag_ready = 1'b0;
        flush = 1'b0;
        chk("t5_count", int'(count), 0);
        chk("t5_offer_valid", int'(tag_valid), 1);
        chk("t5_offer_tag", int'(tag), 0);
        tick();
        chk("t5_no_err", int'(err), 0);

        // 6: whole pool, then mode drop with a high offer pending
        accept(0, 256);
        chk("t6_full_valid", int'(tag_valid), 0);
        chk("t6_full_count", int'(count), 256);
        release_tag(255, 0);
        chk("t6_offer_255", int'(tag), 255);
        chk("t6_valid_255", int'(tag_valid), 1);
        ext = 1'b0;
        release_tag(100, 0);
        chk("t6_high_release_count", int'(count), 254);
        chk("t6_offer_kept", int'(tag), 255);
        accept(255, 1);
        chk("t6_narrow_full_valid", int'(tag_valid), 0);
        chk("t6_final_count", int'(count), 255);
        ext = 1'b1;
        do_flush();

        // TAG_COUNT=200 instance: out-of-range and free-tag releases
        chk("d2_offer_tag", int'(tag2), 0);
        chk("d2_offer_valid", int'(tag2_valid), 1);
        rel2_tag = 8'd220; rel2_valid = 1'b1;
        tick();
        rel2_valid = 1'b0;
        chk("d2_err_220", int'(err2), 1);
        chk("d2_count_220", int'(count2), 0);
        tick();
        chk("d2_err_cleared", int'(err2), 0);
        rel2_tag = 8'd199; rel2_valid = 1'b1;
        tick();
        rel2_valid = 1'b0;
        chk("d2_err_199", int'(err2), 1);
        tick();

        chk("tag_queue_drained", exp_tag_q.size(), 0);
        chk("err_queue_drained", exp_err_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
